// File: rtl/frame_reception.sv
// Receive-side MAC framer: forwards fixed-length payload to the RX FIFO and CRC
// engine, captures the trailing 4-byte CRC and reports per-frame status.
module frame_reception #(
    parameter int unsigned PAYLOAD_LEN = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic        crc_init,
    output logic        crc_en,
    output logic [7:0]  crc_byte,
    input  logic [31:0] crc_in,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        ovf_err,
    output logic [7:0]  rx_len
);

    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, REPORT, DRAIN} state_t;

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    state_t      state;
    logic [7:0]  count;
    logic [7:0]  wr_cnt;
    logic [1:0]  crc_cnt;
    logic        ovf;
    logic [31:0] rx_crc;
    logic [31:0] crc_next;
    logic        is_payload;

    // Status is registered on the edge that samples the last CRC byte, so the
    // comparison uses the shifted-in value rather than waiting a cycle for rx_crc.
    assign crc_next   = {rx_crc[23:0], rx_data};
    assign is_payload = rx_valid && (state == IDLE || state == PAYLOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            wr_cnt       <= '0;
            crc_cnt      <= '0;
            ovf          <= 1'b0;
            rx_crc       <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            crc_en       <= 1'b0;
            crc_byte     <= '0;
            crc_init     <= 1'b1;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            crc_err      <= 1'b0;
            len_err      <= 1'b0;
            ovf_err      <= 1'b0;
            rx_len       <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            crc_en     <= 1'b0;
            frame_done <= 1'b0;

            if (is_payload) begin
                crc_en       <= 1'b1;
                crc_byte     <= rx_data;
                fifo_wr_en   <= !fifo_full;
                fifo_wr_data <= rx_data;
            end

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        count    <= 8'd1;
                        wr_cnt   <= fifo_full ? 8'd0 : 8'd1;
                        ovf      <= fifo_full;
                        crc_cnt  <= '0;
                        crc_init <= 1'b0;
                        state    <= (PAYLOAD_LEN == 1) ? CRC : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!rx_valid) begin
                        frame_done <= 1'b1;
                        len_err    <= 1'b1;
                        frame_ok   <= 1'b0;
                        crc_err    <= 1'b0;
                        ovf_err    <= ovf;
                        rx_len     <= wr_cnt;
                        crc_init   <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        count  <= count + 8'd1;
                        wr_cnt <= wr_cnt + {7'd0, !fifo_full};
                        ovf    <= ovf | fifo_full;
                        if (count == LAST_IDX) begin
                            crc_cnt <= '0;
                            state   <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (!rx_valid) begin
                        frame_done <= 1'b1;
                        len_err    <= 1'b1;
                        frame_ok   <= 1'b0;
                        crc_err    <= 1'b0;
                        ovf_err    <= ovf;
                        rx_len     <= wr_cnt;
                        crc_init   <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        rx_crc  <= crc_next;
                        crc_cnt <= crc_cnt + 2'd1;
                        if (crc_cnt == 2'd3) begin
                            frame_done <= 1'b1;
                            crc_err    <= (crc_next != crc_in);
                            len_err    <= 1'b0;
                            ovf_err    <= ovf;
                            frame_ok   <= (crc_next == crc_in) && !ovf;
                            rx_len     <= wr_cnt;
                            state      <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    crc_init <= !rx_valid;
                    state    <= rx_valid ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (!rx_valid) begin
                        crc_init <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    crc_init <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_reception.sv
// Directed bench for frame_reception: good/bad CRC, overflow, truncation,
// trailing bytes and reset mid-frame, with a constant CRC-engine stub.
module tb_frame_reception;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_byte;
    logic [31:0] crc_in;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        ovf_err;
    logic [7:0]  rx_len;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned wr_n   = 0;
    int unsigned crc_n  = 0;
    int unsigned done_n = 0;
    logic [7:0]  wr_bytes [32];

    always #5 clk = ~clk;

    // CRC engine stub: always reports the agreed CRC for the test payload.
    assign crc_in = 32'hDEADBEEF;

    frame_reception #(.PAYLOAD_LEN(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .crc_init     (crc_init),
        .crc_en       (crc_en),
        .crc_byte     (crc_byte),
        .crc_in       (crc_in),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .crc_err      (crc_err),
        .len_err      (len_err),
        .ovf_err      (ovf_err),
        .rx_len       (rx_len)
    );

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (wr_n < 32) wr_bytes[wr_n] = fifo_wr_data;
            wr_n++;
        end
        if (crc_en) crc_n++;
        if (frame_done) done_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        wr_n   = 0;
        crc_n  = 0;
        done_n = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Payload bytes are 1..n_pay; bytes numbered full_lo..full_hi see fifo_full.
    task automatic send_frame(input int unsigned n_pay, input logic [31:0] crc_word,
                              input int unsigned n_crc, input int unsigned full_lo,
                              input int unsigned full_hi, input int unsigned n_trail);
        clear_counts();
        check("crc_init_idle", crc_init, 1'b1);
        for (int unsigned i = 1; i <= n_pay; i++) begin
            fifo_full = (i >= full_lo) && (i <= full_hi);
            send_byte(8'(i));
            if (i == 1) check("crc_init_first", crc_init, 1'b0);
        end
        fifo_full = 1'b0;
        for (int unsigned k = 0; k < n_crc; k++)
            send_byte(crc_word[31 - 8*k -: 8]);
        for (int unsigned t = 0; t < n_trail; t++)
            send_byte(8'hA5);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_crc_init", crc_init, 1'b1);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_crc_en", crc_en, 1'b0);
        check("rst_frame_ok", frame_ok, 1'b0);
        check("rst_rx_len", rx_len, 8'd0);
        rst_n = 1'b1;
        idle(2);

        // Good frame
        send_frame(12, 32'hDEADBEEF, 4, 99, 99, 0);
        idle(6);
        check("good_wr_n", wr_n, 12);
        for (int unsigned i = 0; i < 12; i++)
            check("good_wr_data", wr_bytes[i], i + 1);
        check("good_done", done_n, 1);
        check("good_ok", frame_ok, 1'b1);
        check("good_crc_err", crc_err, 1'b0);
        check("good_rx_len", rx_len, 8'd12);

        // Bad CRC
        send_frame(12, 32'hDEADBEEE, 4, 99, 99, 0);
        idle(6);
        check("bad_wr_n", wr_n, 12);
        check("bad_done", done_n, 1);
        check("bad_crc_err", crc_err, 1'b1);
        check("bad_ok", frame_ok, 1'b0);
        check("bad_len_err", len_err, 1'b0);

        // Overflow on payload bytes 5-6
        send_frame(12, 32'hDEADBEEF, 4, 5, 6, 0);
        idle(6);
        check("ovf_wr_n", wr_n, 10);
        check("ovf_crc_n", crc_n, 12);
        check("ovf_wr_byte4", wr_bytes[4], 8'd7);
        check("ovf_err", ovf_err, 1'b1);
        check("ovf_ok", frame_ok, 1'b0);
        check("ovf_crc_err", crc_err, 1'b0);
        check("ovf_rx_len", rx_len, 8'd10);

        // Truncation after 7 payload bytes
        send_frame(7, 32'h0, 0, 99, 99, 0);
        idle(1);
        check("trunc_done_next", frame_done, 1'b1);
        check("trunc_len_err", len_err, 1'b1);
        check("trunc_rx_len", rx_len, 8'd7);
        check("trunc_ok", frame_ok, 1'b0);
        check("trunc_crc_err", crc_err, 1'b0);
        check("trunc_ovf_err", ovf_err, 1'b0);
        idle(6);
        check("trunc_done_n", done_n, 1);
        check("trunc_hold", len_err, 1'b1);

        // Trailing byte after a good frame, then another good frame
        send_frame(12, 32'hDEADBEEF, 4, 99, 99, 1);
        idle(4);
        check("trail_wr_n", wr_n, 12);
        check("trail_crc_n", crc_n, 12);
        check("trail_done", done_n, 1);
        check("trail_ok", frame_ok, 1'b1);
        check("trail_len_err", len_err, 1'b0);
        send_frame(12, 32'hDEADBEEF, 4, 99, 99, 0);
        idle(6);
        check("after_trail_wr_n", wr_n, 12);
        check("after_trail_done", done_n, 1);
        check("after_trail_ok", frame_ok, 1'b1);

        // Reset during CRC byte 2
        send_frame(12, 32'hDEADBEEF, 1, 99, 99, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hAD;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_crc_init", crc_init, 1'b1);
        check("mrst_frame_ok", frame_ok, 1'b0);
        check("mrst_rx_len", rx_len, 8'd0);
        check("mrst_wr_en", fifo_wr_en, 1'b0);
        check("mrst_done", frame_done, 1'b0);
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        idle(4);
        check("mrst_done_n", done_n, 0);
        send_frame(12, 32'hDEADBEEF, 4, 99, 99, 0);
        idle(6);
        check("post_rst_wr_n", wr_n, 12);
        check("post_rst_done", done_n, 1);
        check("post_rst_ok", frame_ok, 1'b1);
        check("post_rst_rx_len", rx_len, 8'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_reception.md
# frame_reception

Receive-side counterpart of the MAC frame transmitter. Accepts a byte stream (rx_data/rx_valid), writes the fixed-length payload into the RX FIFO, and drives an external CRC module over the payload bytes. It captures the 4 trailing CRC bytes (MSB first), compares them against the computed CRC, and reports per-frame status. It sits between the PHY-side byte interface and the RX FIFO / CRC module.

## Interface
- PAYLOAD_LEN, 12, payload bytes per frame (1..255); followed by exactly 4 CRC bytes.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte, sampled when rx_valid=1.
- rx_valid  in  1  byte strobe; must stay high for the whole frame.
- fifo_full  in  1  RX FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe (registered).
- fifo_wr_data  out  8  FIFO write byte (registered).
- crc_init  out  1  high while in IDLE; external CRC module reloads 0xFFFFFFFF.
- crc_en  out  1  CRC update strobe for crc_byte (registered, identical timing to fifo_wr_en but independent of fifo_full).
- crc_byte  out  8  byte to CRC module.
- crc_in  in  32  running CRC from external module.
- frame_done  out  1  one-cycle pulse at end/abort of a frame.
- frame_ok  out  1  status: CRC match, no overflow, full length.
- crc_err  out  1  status: received CRC != crc_in.
- len_err  out  1  status: rx_valid dropped before last CRC byte.
- ovf_err  out  1  status: ≥1 payload byte dropped due to fifo_full.
- rx_len  out  8  payload bytes actually written to FIFO in the last frame.

## Operation
- States: IDLE, PAYLOAD, CRC, REPORT, DRAIN.
- IDLE: crc_init=1. rx_valid=1 -> byte is payload byte 0; count=1; -> PAYLOAD (or CRC if PAYLOAD_LEN=1).
- PAYLOAD: each rx_valid byte -> count+1, forwarded to CRC; written to FIFO unless fifo_full (then dropped, ovf flag set). After byte PAYLOAD_LEN-1 -> CRC, crc_cnt=0.
- CRC: each byte shifted into rx_crc[31:0] from the left (first byte -> [31:24]). CRC bytes are never written to FIFO nor sent to CRC module. After 4th byte -> REPORT.
- REPORT (1 cycle): frame_done=1; crc_err=(rx_crc!=crc_in); len_err=0; ovf_err=ovf; frame_ok=!crc_err&&!ovf; rx_len=written count. Then rx_valid=1 -> DRAIN, else IDLE.
- DRAIN: ignore bytes (no FIFO/CRC writes) until rx_valid=0 -> IDLE. Trailing bytes never start a new frame.
- Abort: rx_valid=0 in PAYLOAD or CRC -> next cycle frame_done=1, len_err=1, frame_ok=0, crc_err=0, ovf_err=ovf, rx_len=written count; -> IDLE. Bytes already in FIFO remain; the consumer discards them on frame_ok=0.
- Status outputs (frame_ok, crc_err, len_err, ovf_err, rx_len) hold until the next frame_done.
- Counters are 8-bit; count never exceeds PAYLOAD_LEN, so no wrap.

## Timing
- Reset values: fifo_wr_en=0, fifo_wr_data=0, crc_en=0, crc_byte=0, crc_init=1, frame_done=0, frame_ok=0, crc_err=0, len_err=0, ovf_err=0, rx_len=0; state IDLE; rx_crc=0.
- Payload byte sampled at edge N -> fifo_wr_en/crc_en high in cycle N+1.
- crc_in must reflect all payload bytes by REPORT. The CRC module updates at the edge ending the last crc_en cycle; REPORT is ≥3 cycles later.
- crc_init deasserts in the cycle after the first byte is sampled (cycle N+1, alongside the first crc_en).
- Back-to-back frames: a frame may start in the cycle after REPORT, or after DRAIN sees rx_valid=0, and only after at least one cycle with rx_valid=0.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values; no frame_done is issued.

## Test plan
- Good frame: 12 bytes 0x01..0x0C, bench CRC stub sets crc_in=0xDEADBEEF, CRC bytes DE AD BE EF -> 12 FIFO writes 0x01..0x0C, frame_done once, frame_ok=1, rx_len=12.
- Bad CRC: same payload, CRC bytes DE AD BE EE -> crc_err=1, frame_ok=0, 12 FIFO writes.
- Overflow: fifo_full high during payload bytes 5–6 -> 10 FIFO writes, 12 crc_en pulses, ovf_err=1, frame_ok=0, rx_len=10.
- Truncation: rx_valid drops after 7 payload bytes -> frame_done next cycle, len_err=1, rx_len=7, no REPORT.
- Trailing byte: good frame followed by a 17th rx_valid byte -> status from REPORT, DRAIN ignores the byte (no FIFO write), next frame after rx_valid=0 received normally.
- Reset mid-frame: rst_n low during CRC byte 2 -> all outputs at reset values, no frame_done; the subsequent good frame passes.
